// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, constants and the parity helper for the UART
//               transmit engine.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    // Widest supported data word; narrower words are zero-extended to this.
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Zero-extension of narrow words leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0]               mode);
        case (mode)
            PARITY_EVEN: return ^data;
            PARITY_ODD:  return ~(^data);
            default:     return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
//               terminal count as the bit-end tick. Restarts on clear.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Free-running modulo counter, forced to zero when a frame is accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || (count == LAST_COUNT)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine
// Description : UART transmit serializer with valid/ready byte handshake,
//               internal baud divider, optional parity and 1 or 2 stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Reject unsupported configurations at elaboration.
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_engine: PARITY_MODE must be 0, 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx_engine: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_engine: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_engine: CLKS_PER_BIT must be at least 2");
    end

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [1:0]       PMODE     = 2'(PARITY_MODE);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 par;
    logic                 tick;
    logic                 accept;

    // Status comes from the registered state only.
    assign tx_ready = (state == IDLE);
    assign tx_busy  = ~tx_ready;
    assign accept   = tx_valid & tx_ready;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .tick    (tick)
    );

    // Frame sequencer: the line value for the next bit is registered on the
    // same edge that moves the state, so the line only changes on bit ends.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            par       <= 1'b0;
            tx_serial <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shreg     <= tx_data;
                        par       <= parity_bit(MAX_DATA_BITS'(tx_data), PMODE);
                        bit_idx   <= '0;
                        stop_idx  <= 1'b0;
                        tx_serial <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_serial <= shreg[0];
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
                            if (PARITY_MODE != 0) begin
                                tx_serial <= par;
                                state     <= PARITY;
                            end else begin
                                tx_serial <= 1'b1;
                                state     <= STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            shreg     <= shreg >> 1;
                            tx_serial <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx_serial <= 1'b1;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_idx == LAST_STOP) begin
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_serial <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_engine
// Description : Self-checking bench for uart_tx_engine. Five instances cover
//               8N1, even parity, odd parity, two stop bits and 5-bit data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [8:0] data [5];
    logic [4:0] valid;
    logic [4:0] ready;
    logic [4:0] serial;
    logic [4:0] busy;
    logic [4:0] done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset_n(reset_n), .tx_data(data[0][7:0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_serial(serial[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
        .clk(clk), .reset_n(reset_n), .tx_data(data[1][7:0]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_serial(serial[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
        .clk(clk), .reset_n(reset_n), .tx_data(data[2][7:0]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_serial(serial[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
        .clk(clk), .reset_n(reset_n), .tx_data(data[3][7:0]), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .tx_serial(serial[3]), .tx_busy(busy[3]), .tx_done(done[3]));
    uart_tx_engine #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) u4 (
        .clk(clk), .reset_n(reset_n), .tx_data(data[4][4:0]), .tx_valid(valid[4]),
        .tx_ready(ready[4]), .tx_serial(serial[4]), .tx_busy(busy[4]), .tx_done(done[4]));

    function automatic int nd_of(input int k);
        return (k == 4) ? 5 : 8;
    endfunction
    function automatic int pm_of(input int k);
        return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    endfunction
    function automatic int ns_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    // Reference frame: list of line levels, one per bit period.
    function automatic int build_frame(input logic [8:0] d, input int nd, input int pm,
                                       input int ns, output logic [15:0] bits);
        int ones = 0;
        int n = 0;
        bits = '1;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nd; i++) begin
            bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (pm == 1) begin bits[n] = (ones % 2 == 1); n++; end
        else if (pm == 2) begin bits[n] = (ones % 2 == 0); n++; end
        for (int i = 0; i < ns; i++) begin bits[n] = 1'b1; n++; end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a byte and return right after the edge that should accept it.
    task automatic start_frame(input int k, input logic [8:0] d);
        @(negedge clk);
        data[k]  = d;
        valid[k] = 1'b1;
        @(posedge clk);
    endtask

    // Follow one frame from the accept edge to the tx_done cycle.
    // vmode 0: drop valid; 1: hold valid and change data to newd;
    // 2: random valid pulses and data changes while busy.
    task automatic run_frame(input int k, input logic [8:0] d, input int vmode,
                             input logic [8:0] newd, input int exp_len, output int par_seen);
        logic [15:0] bits;
        int nb, done_at, busy_cnt, glitches, par_pos;
        nb       = build_frame(d, nd_of(k), pm_of(k), ns_of(k), bits);
        par_pos  = (1 + nd_of(k)) * CPB + CPB / 2;
        par_seen = -1;
        done_at  = -1;
        busy_cnt = 0;
        glitches = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            case (vmode)
                0: if (n == 0) valid[k] = 1'b0;
                1: if (n == 1) data[k] = newd;
                default: begin
                    valid[k] = (n % 7 == 3) && !done[k];
                    data[k]  = 9'($urandom);
                end
            endcase
            if (done[k]) begin
                done_at = n;
                break;
            end
            if (busy[k]) busy_cnt++;
            if (n < nb * CPB) begin
                if (serial[k] !== bits[n / CPB]) glitches++;
                if (n % CPB == CPB / 2)
                    chk($sformatf("u%0d_bit%0d", k, n / CPB), int'(serial[k]), int'(bits[n / CPB]));
            end else begin
                glitches++;
            end
            if (n == par_pos) par_seen = int'(serial[k]);
        end
        chk($sformatf("u%0d_done_time", k), done_at, exp_len);
        chk($sformatf("u%0d_busy_cycles", k), busy_cnt, exp_len);
        chk($sformatf("u%0d_line_glitches", k), glitches, 0);
        chk($sformatf("u%0d_ready_at_done", k), int'(ready[k]), 1);
        chk($sformatf("u%0d_serial_at_done", k), int'(serial[k]), 1);
    endtask

    typedef struct {
        int         k;
        logic [8:0] d;
        int         exp_len;
        int         exp_par;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int p;
        int nb;
        int k;
        int dcnt;
        int bad;
        logic [8:0]  d;
        logic [15:0] bits;

        tbl[0] = '{k: 0, d: 9'h055, exp_len: 40, exp_par: -1};
        tbl[1] = '{k: 1, d: 9'h007, exp_len: 44, exp_par: 1};
        tbl[2] = '{k: 2, d: 9'h007, exp_len: 44, exp_par: 0};
        tbl[3] = '{k: 1, d: 9'h0A5, exp_len: 44, exp_par: 0};
        tbl[4] = '{k: 3, d: 9'h0FF, exp_len: 44, exp_par: -1};
        tbl[5] = '{k: 4, d: 9'h1FB, exp_len: 28, exp_par: -1};

        reset_n = 1'b0;
        valid   = '0;
        for (int i = 0; i < 5; i++) data[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_serial", int'(serial), 31);
        chk("rst_ready",  int'(ready),  31);
        chk("rst_busy",   int'(busy),   0);
        chk("rst_done",   int'(done),   0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_serial", int'(serial), 31);
        chk("idle_ready",  int'(ready),  31);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            start_frame(tbl[i].k, tbl[i].d);
            run_frame(tbl[i].k, tbl[i].d, 0, 9'h0, tbl[i].exp_len, p);
            if (tbl[i].exp_par >= 0)
                chk($sformatf("vec%0d_parity", i), p, tbl[i].exp_par);
        end

        // Back-to-back with valid held: second accept on the edge after tx_done.
        start_frame(0, 9'h031);
        run_frame(0, 9'h031, 1, 9'h032, 40, p);
        run_frame(0, 9'h032, 0, 9'h0, 40, p);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (!ready[0] || busy[0] || !serial[0] || done[0]) bad++;
        end
        chk("b2b_idle_after_two", bad, 0);

        // Reset in the middle of a frame aborts it silently.
        start_frame(0, 9'h0A3);
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (n == 0) valid[0] = 1'b0;
            if (n == 14) reset_n = 1'b0;
        end
        @(negedge clk);
        chk("abort_serial", int'(serial[0]), 1);
        chk("abort_ready",  int'(ready[0]),  1);
        chk("abort_busy",   int'(busy[0]),   0);
        chk("abort_done",   int'(done[0]),   0);
        reset_n = 1'b1;
        dcnt = 0;
        bad  = 0;
        repeat (50) begin
            @(negedge clk);
            if (done[0]) dcnt++;
            if (!serial[0]) bad++;
        end
        chk("abort_no_done", dcnt, 0);
        chk("abort_line_high", bad, 0);
        start_frame(0, 9'h03C);
        run_frame(0, 9'h03C, 0, 9'h0, 40, p);

        // Randomized frames against the reference model.
        for (int it = 0; it < 16; it++) begin
            k  = $urandom_range(0, 4);
            d  = 9'($urandom);
            nb = build_frame(d, nd_of(k), pm_of(k), ns_of(k), bits);
            start_frame(k, d);
            run_frame(k, d, ($urandom_range(0, 1) == 1) ? 2 : 0, 9'h0, nb * CPB, p);
            valid[k] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised UART transmit engine. It replaces the two-state button-driven load controller with a complete serializer. It has a valid/ready byte handshake, an internal baud divider, configurable data width, parity mode and stop-bit count. It sits between the user/TX data source and the board TX pin, and provides busy and done status.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal values >= 2.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd; 3 is illegal and is rejected at elaboration.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  in  1  system clock; the single clock domain.
reset_n  in  1  reset; synchronous, active-low.
tx_data  in  DATA_BITS  byte to send; sampled only at accept.
tx_valid  in  1  source has data.
tx_ready  out  1  engine can accept; high only in IDLE.
tx_serial  out  1  serial line; idle high; registered.
tx_busy  out  1  frame in progress; equals ~tx_ready.
tx_done  out  1  one-cycle pulse at end of last stop bit.

Behaviour:
- Reset (reset_n low at posedge clk):
  - state = IDLE, tx_serial = 1, tx_done = 0, tx_ready = 1, tx_busy = 0.
  - Baud counter, bit index and shift register are cleared.
- Reset asserted mid-frame aborts the frame. tx_serial is 1 from the next edge, and no tx_done pulse is produced.
- Accept occurs at a posedge with tx_valid & tx_ready. At that edge:
  - tx_data is latched into the shift register.
  - Parity is computed from the latched data: even = XOR of the data bits, odd = its inverse.
  - state becomes START, tx_serial becomes 0, and the baud counter is set to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Each non-IDLE state holds its bit for exactly CLKS_PER_BIT clocks.
  - The baud counter counts 0..CLKS_PER_BIT-1. Its terminal count is the bit-end tick.
  - START -> DATA on tick.
  - DATA shifts LSB first, bit index 0..DATA_BITS-1. DATA -> PARITY after the last bit if PARITY_MODE != 0, otherwise DATA -> STOP.
  - PARITY drives the parity bit. PARITY -> STOP on tick.
  - STOP drives 1 for STOP_BITS bit periods. STOP -> IDLE on the tick of the last stop bit.
- tx_serial changes only on bit boundaries; there are no glitches. Its value is registered in the same edge as the state change.
- Frame length = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * CLKS_PER_BIT clocks, measured from the accept edge to the IDLE-entry edge.
- tx_done is 1 for exactly the first cycle after IDLE entry, and tx_ready is 1 in that same cycle.
- Back-to-back frames: if tx_valid is held high, the next accept occurs at the edge ending the tx_done cycle. Accept-to-accept spacing is therefore frame length + 1 clock, and the line is held high for one extra clock.
- tx_valid while busy is ignored; there is no queueing. Changes to tx_data during a frame do not affect the frame in progress.
- tx_ready and tx_busy are decoded from the registered state only; there is no combinational path from tx_valid.
- Counter width = $clog2(CLKS_PER_BIT). Bit-index width = $clog2(DATA_BITS). Neither counter wraps past its terminal count.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - PARITY_NONE/EVEN/ODD localparams.
  - function parity_bit(data, mode).
- Sub-module uart_baud_tick:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, reset_n, clear; output tick.
  - Counter restarts on clear at accept and free-runs otherwise.
- The FSM, shift register and bit index stay in uart_tx_engine.

Test Plan:
- Common bench setup: CLKS_PER_BIT = 4, DATA_BITS = 8, and a line monitor that samples mid-bit.
- Single frame, PARITY_MODE = 0, STOP_BITS = 1, send 0x55 -> line reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop). tx_done pulses once exactly 40 clocks after accept. tx_busy is high for 40 cycles.
- PARITY_MODE = 1, send 0x07 -> parity bit = 1, 11-bit frame. PARITY_MODE = 2, send 0x07 -> parity bit = 0. Send 0xA5 with even parity -> parity bit = 0.
- STOP_BITS = 2, send 0xFF -> line stays high for 8 clocks after the last data bit, and tx_done follows 44 clocks after accept (no parity).
- tx_valid held high with 0x31 then 0x32 -> second accept occurs at the edge after the tx_done cycle (spacing 41 clocks). tx_valid pulses during busy are ignored, and the monitor decodes exactly 2 bytes.
- reset_n pulled low at clock 15 of a frame -> the next edge gives tx_serial = 1, tx_ready = 1 and no tx_done. A new frame 0x3C is then sent cleanly.
- DATA_BITS = 5 build, send 0x1B -> 7-bit frame (1+5+1). Upper tx_data bits are don't-care.
